// File: rtl/nn_ram_arbiter_if.sv
// Shared-RAM arbiter bundle: NN engine port, CPU port and the single RAM port.
// Zero latency itself; it only groups signals. The arbiter uses the slave side.
// Backpressure: NN sees nn_gnt and stalls. The CPU holds its request until cpu_ack.
interface nn_ram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    // NN engine side
    logic              nn_req;
    logic              nn_we;
    logic              nn_lock;
    logic [ADDR_W-1:0] nn_addr;
    logic [DATA_W-1:0] nn_wd;
    logic              nn_gnt;
    logic [DATA_W-1:0] nn_rd;

    // CPU side
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wd;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rd;

    // Shared RAM port (asynchronous read)
    logic [ADDR_W-1:0] RAM_address;
    logic [DATA_W-1:0] RAM_wd;
    logic              RAM_we;
    logic [DATA_W-1:0] RAM_rd;

    modport slave (
        input  nn_req, nn_we, nn_lock, nn_addr, nn_wd,
        input  cpu_req, cpu_we, cpu_addr, cpu_wd,
        input  RAM_rd,
        output nn_gnt, nn_rd, cpu_ack, cpu_rd,
        output RAM_address, RAM_wd, RAM_we
    );

    modport master (
        output nn_req, nn_we, nn_lock, nn_addr, nn_wd,
        output cpu_req, cpu_we, cpu_addr, cpu_wd,
        output RAM_rd,
        input  nn_gnt, nn_rd, cpu_ack, cpu_rd,
        input  RAM_address, RAM_wd, RAM_we
    );
endinterface

// File: rtl/nn_ram_arbiter.sv
// Shared-RAM arbiter between an NN engine (burst lock) and a CPU (single accesses).
// Latency: NN owns RAM one cycle after the request. A CPU access takes 1 cycle, and cpu_ack follows it.
// Backpressure: NN stalls while nn_gnt=0. The CPU holds its request until cpu_ack.
// NN_ARB_STARVE_GUARD_EN enables the CPU wait counter, which can preempt a locked NN burst.
module nn_ram_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    nn_ram_arbiter_if.slave   bus
);

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_max_wait_range
        $error("MAX_WAIT must be within 1..255");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        NN_OWN  = 2'd1,
        CPU_OWN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              cpu_ack_q;
    logic [DATA_W-1:0] cpu_rd_q;
    logic              cpu_req_eff;
    logic              starve;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_wd;
    logic              ram_we;

    // The CPU still holds req during its ack cycle; that is not a new request.
    assign cpu_req_eff = bus.cpu_req & ~cpu_ack_q;

`ifdef NN_ARB_STARVE_GUARD_EN
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
    logic [7:0] wait_cnt;
    assign starve = cpu_req_eff && (wait_cnt == WAIT_LIMIT);
`else
    assign starve = 1'b0;
`endif

    // Next-owner selection; NN wins ties out of IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.nn_req)       state_nxt = NN_OWN;
                else if (cpu_req_eff) state_nxt = CPU_OWN;
                else                  state_nxt = IDLE;
            end
            NN_OWN: begin
                if (bus.nn_lock)      state_nxt = starve ? CPU_OWN : NN_OWN;
                else if (cpu_req_eff) state_nxt = CPU_OWN;
                else if (bus.nn_req)  state_nxt = NN_OWN;
                else                  state_nxt = IDLE;
            end
            // cpu_req seen here is the access just served, so it never re-enters CPU_OWN.
            CPU_OWN: begin
                if (bus.nn_req)       state_nxt = NN_OWN;
                else                  state_nxt = IDLE;
            end
            default:                  state_nxt = IDLE;
        endcase
    end

    // State, CPU completion and wait counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cpu_ack_q <= 1'b0;
            cpu_rd_q  <= '0;
`ifdef NN_ARB_STARVE_GUARD_EN
            wait_cnt  <= 8'd0;
`endif
        end else begin
            state     <= state_nxt;
            cpu_ack_q <= (state == CPU_OWN);
            if (state == CPU_OWN && !bus.cpu_we) begin
                cpu_rd_q <= bus.RAM_rd;
            end
`ifdef NN_ARB_STARVE_GUARD_EN
            if (state_nxt == CPU_OWN) begin
                wait_cnt <= 8'd0;
            end else if (cpu_req_eff && state != CPU_OWN && wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
`endif
        end
    end

    // RAM port follows the current owner only; idle drives zeros.
    always_comb begin
        ram_address = '0;
        ram_wd      = '0;
        ram_we      = 1'b0;
        case (state)
            NN_OWN: begin
                ram_address = bus.nn_addr;
                ram_wd      = bus.nn_wd;
                ram_we      = bus.nn_we;
            end
            CPU_OWN: begin
                ram_address = bus.cpu_addr;
                ram_wd      = bus.cpu_wd;
                ram_we      = bus.cpu_we;
            end
            default: begin
                ram_address = '0;
                ram_wd      = '0;
                ram_we      = 1'b0;
            end
        endcase
    end

    assign bus.RAM_address = ram_address;
    assign bus.RAM_wd      = ram_wd;
    assign bus.RAM_we      = ram_we;
    assign bus.nn_gnt      = (state == NN_OWN);
    assign bus.nn_rd       = bus.RAM_rd;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.cpu_rd      = cpu_rd_q;

endmodule

// File: tb/tb_nn_ram_arbiter.sv
// Testbench for nn_ram_arbiter: table of CPU accesses plus hand-written arbitration sequences.
// Inputs are driven and outputs are sampled on the falling edge. A RAM model answers the RAM port.
// CPU read data is checked against a scoreboard queue that is filled when each request is issued.
module tb_nn_ram_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nn_ram_arbiter_if #(.ADDR_W(10), .DATA_W(8)) bus ();

    nn_ram_arbiter #(.ADDR_W(10), .DATA_W(8), .MAX_WAIT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Shared RAM model with asynchronous read.
    logic [7:0] mem [0:1023];
    assign bus.RAM_rd = mem[bus.RAM_address];
    always @(posedge clk) begin
        if (bus.RAM_we) mem[bus.RAM_address] <= bus.RAM_wd;
    end

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       we;
        logic [9:0] addr;
        logic [7:0] wd;
        logic [7:0] exp_rd;
    } vec_t;
    vec_t vt [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input string name);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: cpu_ack with empty scoreboard, cpu_rd 0x%0h", name, bus.cpu_rd);
        end else begin
            check(name, 32'(bus.cpu_rd), 32'(exp_q.pop_front()));
        end
    endtask

    // Single CPU access from IDLE. The caller must be positioned at a falling edge.
    task automatic cpu_op(input logic we, input logic [9:0] addr, input logic [7:0] wd,
                          input logic [7:0] exp_rd);
        int         lat;
        bit         got;
        logic [9:0] pa;
        logic       pw;
        logic [7:0] pwd;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = we;
        bus.cpu_addr = addr;
        bus.cpu_wd   = wd;
        exp_q.push_back(exp_rd);
        got = 0; lat = 0; pa = '0; pw = 1'b0; pwd = '0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (bus.cpu_ack) begin
                got = 1;
                check("cpu_latency", 32'(lat), 32'd2);
                check("cpu_ram_addr", 32'(pa), 32'(addr));
                check("cpu_ram_we", 32'(pw), 32'(we));
                if (we) check("cpu_ram_wd", 32'(pwd), 32'(wd));
                sb_pop("cpu_rd");
                bus.cpu_req = 1'b0;
            end else begin
                pa  = bus.RAM_address;
                pw  = bus.RAM_we;
                pwd = bus.RAM_wd;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL cpu_ack_timeout: got no ack expected ack within 10 cycles");
            void'(exp_q.pop_back());
            bus.cpu_req = 1'b0;
        end
        @(negedge clk);
        check("cpu_ack_pulse", 32'(bus.cpu_ack), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first_low;
        int low_cnt;
        int ack_at;

        vt[0] = '{1'b1, 10'h155, 8'h3A, 8'h00};
        vt[1] = '{1'b0, 10'h155, 8'h00, 8'h3A};
        vt[2] = '{1'b1, 10'h2AA, 8'hC5, 8'h3A};
        vt[3] = '{1'b0, 10'h2AA, 8'h00, 8'hC5};
        vt[4] = '{1'b0, 10'h000, 8'h00, 8'h00};
        vt[5] = '{1'b1, 10'h3FF, 8'hFF, 8'h00};
        vt[6] = '{1'b0, 10'h3FF, 8'h00, 8'hFF};
        vt[7] = '{1'b0, 10'h155, 8'h00, 8'h3A};

        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

        reset        = 1'b0;
        bus.nn_req   = 1'b0; bus.nn_we  = 1'b0; bus.nn_lock = 1'b0;
        bus.nn_addr  = '0;   bus.nn_wd  = '0;
        bus.cpu_req  = 1'b0; bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;   bus.cpu_wd = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_nn_gnt", 32'(bus.nn_gnt), 32'd0);
        check("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        check("rst_cpu_rd", 32'(bus.cpu_rd), 32'd0);
        check("rst_ram_we", 32'(bus.RAM_we), 32'd0);
        check("rst_ram_addr", 32'(bus.RAM_address), 32'd0);
        check("rst_ram_wd", 32'(bus.RAM_wd), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_nn_gnt", 32'(bus.nn_gnt), 32'd0);
        check("idle_ram_we", 32'(bus.RAM_we), 32'd0);
        check("idle_ram_addr", 32'(bus.RAM_address), 32'd0);
        check("idle_cpu_ack", 32'(bus.cpu_ack), 32'd0);

        // CPU accesses from IDLE
        for (int i = 0; i < 8; i++) begin
            cpu_op(vt[i].we, vt[i].addr, vt[i].wd, vt[i].exp_rd);
        end

        // Simultaneous requests: NN writes 0x5A at 0x010, then the CPU reads it back.
        bus.nn_req   = 1'b1; bus.nn_lock = 1'b0; bus.nn_we = 1'b1;
        bus.nn_addr  = 10'h010; bus.nn_wd = 8'h5A;
        bus.cpu_req  = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'h010; bus.cpu_wd = 8'h00;
        exp_q.push_back(8'h5A);
        @(negedge clk);
        check("tie_nn_gnt", 32'(bus.nn_gnt), 32'd1);
        check("tie_nn_addr", 32'(bus.RAM_address), 32'h010);
        check("tie_nn_we", 32'(bus.RAM_we), 32'd1);
        check("tie_nn_wd", 32'(bus.RAM_wd), 32'h5A);
        check("tie_nn_rd", 32'(bus.nn_rd), 32'h00);
        @(negedge clk);
        check("tie_cpu_gnt", 32'(bus.nn_gnt), 32'd0);
        check("tie_cpu_addr", 32'(bus.RAM_address), 32'h010);
        check("tie_cpu_we", 32'(bus.RAM_we), 32'd0);
        check("tie_cpu_noack", 32'(bus.cpu_ack), 32'd0);
        @(negedge clk);
        check("tie_cpu_ack", 32'(bus.cpu_ack), 32'd1);
        if (bus.cpu_ack) sb_pop("tie_cpu_rd");
        check("tie_nn_back", 32'(bus.nn_gnt), 32'd1);
        bus.cpu_req = 1'b0; bus.nn_req = 1'b0; bus.nn_we = 1'b0;
        @(negedge clk);
        check("tie_ack_pulse", 32'(bus.cpu_ack), 32'd0);
        check("tie_idle_gnt", 32'(bus.nn_gnt), 32'd0);

        // Locked NN burst with a CPU read of 0x155 held pending.
        bus.nn_req  = 1'b1; bus.nn_lock = 1'b1; bus.nn_we = 1'b0; bus.nn_addr = 10'h020;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'h155;
        exp_q.push_back(8'h3A);
        first_low = -1; low_cnt = 0; ack_at = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (!bus.nn_gnt) begin
                low_cnt++;
                if (first_low < 0) first_low = c;
                check("starve_cpu_addr", 32'(bus.RAM_address), 32'h155);
                check("starve_cpu_we", 32'(bus.RAM_we), 32'd0);
            end
            if (bus.cpu_ack) begin
                ack_at = c;
                check("starve_gnt_at_ack", 32'(bus.nn_gnt), 32'd1);
                sb_pop("starve_cpu_rd");
                bus.cpu_req = 1'b0;
            end
        end
`ifdef NN_ARB_STARVE_GUARD_EN
        check("starve_first_low", 32'(first_low), 32'd17);
        check("starve_low_cycles", 32'(low_cnt), 32'd1);
        check("starve_ack_cycle", 32'(ack_at), 32'd18);
`else
        check("lock_low_cycles", 32'(low_cnt), 32'd0);
        check("lock_no_ack", 32'(ack_at), 32'hFFFF_FFFF);
        bus.nn_lock = 1'b0;
        @(negedge clk);
        check("unlock_cpu_gnt", 32'(bus.nn_gnt), 32'd0);
        check("unlock_cpu_addr", 32'(bus.RAM_address), 32'h155);
        @(negedge clk);
        check("unlock_cpu_ack", 32'(bus.cpu_ack), 32'd1);
        if (bus.cpu_ack) sb_pop("unlock_cpu_rd");
        check("unlock_nn_back", 32'(bus.nn_gnt), 32'd1);
        bus.cpu_req = 1'b0;
`endif
        bus.nn_req = 1'b0; bus.nn_lock = 1'b0;
        repeat (2) @(negedge clk);
        check("burst_end_gnt", 32'(bus.nn_gnt), 32'd0);
        check("burst_end_ack", 32'(bus.cpu_ack), 32'd0);

        // Reset during CPU_OWN drops the access.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'h0AA; bus.cpu_wd = 8'h77;
        @(negedge clk);
        check("rstcpu_own_we", 32'(bus.RAM_we), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("rstcpu_no_ack", 32'(bus.cpu_ack), 32'd0);
        check("rstcpu_ram_we", 32'(bus.RAM_we), 32'd0);
        check("rstcpu_ram_addr", 32'(bus.RAM_address), 32'd0);
        check("rstcpu_nn_gnt", 32'(bus.nn_gnt), 32'd0);
        check("rstcpu_cpu_rd", 32'(bus.cpu_rd), 32'd0);
        bus.cpu_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rstcpu_still_no_ack", 32'(bus.cpu_ack), 32'd0);
        @(negedge clk);
        check("rstcpu_later_no_ack", 32'(bus.cpu_ack), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
